cursor_selector: RTL and testbench
==================================

# cursor_selector

Parametrised cursor/colour selection controller for the LED cube. It tracks a user-positioned voxel cursor, previews it on the display (blinking while positioning, steady or colour-cycling while choosing colour) and commits the chosen voxel and colour to the frame store through a valid/ready write port. It sits between the switch/key input logic and the LED display driver. It generalises the fixed 8×8×8, single-rate selector to any cube size, colour width and blink/cycle rate, and adds an explicit commit handshake.

## Interface
Parameters:
- COORD_W, 3, bits per axis coordinate; cube is 2^COORD_W per side
- COLOR_W, 3, colour bits; must be ≥3 (bits [2:0] are R,G,B)
- CLK_HZ, 50_000_000, clock frequency
- BLINK_HZ, 4, cursor blink rate in position mode (full on/off periods per second)
- CYCLE_HZ, 2, colour-step rate in auto-cycle mode

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pos_sel  in  1  level: position mode; coordinates track x/y/z
- col_sel  in  1  level: colour mode
- commit  in  1  level; its rising edge requests a write
- x, y, z  in  COORD_W each  requested cursor coordinates
- c  in  COLOR_W  requested colour; 0 selects auto-cycle
- wr_ready  in  1  frame store accepts the write
- cur_x, cur_y, cur_z  out  COORD_W each  cursor to display driver
- cur_color  out  COLOR_W  preview colour to display driver
- disp_en  out  1  display enable for the cursor voxel
- wr_valid  out  1  write request
- wr_x, wr_y, wr_z  out  COORD_W each  write coordinates
- wr_color  out  COLOR_W  write colour
- busy  out  1  high in COMMIT state

## Operation
- States: IDLE, POS, COL, COMMIT. Encoding is defined in the shared package.
- Priority when several inputs are active: reset > pos_sel > col_sel > commit edge.
- IDLE:
  - Outputs: disp_en=0, cur_* hold their last value.
  - pos_sel → POS.
  - col_sel → COL, using the held cursor.
- POS:
  - Each cycle: cur_x/y/z ← x/y/z; cur_color ← all-ones in [2:0], upper bits 0.
  - disp_en toggles every HALF = CLK_HZ/(2·BLINK_HZ) cycles.
  - On entry, blink phase = on and the blink counter = 0.
  - Exit: pos_sel low and col_sel high → COL; both low → IDLE.
- COL:
  - disp_en=1 steady. Coordinates frozen.
  - c≠0: cur_color ← c every cycle.
  - c=0: cur_color is one-hot R→G→B→R in bits [2:0], stepping every STEP = CLK_HZ/CYCLE_HZ cycles. Restarts at R with the counter cleared on entry to COL, and whenever c changes from non-zero to 0.
  - pos_sel → POS. commit rising edge → COMMIT. col_sel low with no pos_sel → IDLE.
- COMMIT:
  - Entry: wr_x/y/z/color ← cur_x/y/z/cur_color, the colour value shown in that cycle (one-hot when cycling).
  - wr_valid=1 and busy=1. Write payload is stable while wr_valid=1.
  - All mode inputs are ignored, including pos_sel.
  - On the first cycle with wr_valid & wr_ready → IDLE, with wr_valid=0 the next cycle.
- Commit edge detection uses a registered commit_q. A commit held high across entry to COL does not trigger a write.
- Arithmetic: HALF and STEP are computed at elaboration and must be ≥1 (elaboration assertion). Counters are $clog2(max)+1 bits and wrap to 0 at terminal count−1.

## Timing
- All outputs are registered. Input-to-output latency is 1 cycle: x/y/z/c sampled at edge n appear at n+1.
- Reset values:
  - state = IDLE.
  - cur_x/y/z, cur_color, disp_en, wr_valid, busy = 0; wr_* = 0.
  - Counters = 0, commit_q = 0.
- Reset during COMMIT drops wr_valid the next cycle; no write is completed.
- Mode transitions take effect 1 cycle after the sampling edge. disp_en reflects the new state in the same cycle as the state change.
- wr_ready high while wr_valid=0 has no effect.

## Structure
- Package cube_pkg holds:
  - state typedef sel_state_t
  - RGB bit-index constants R_BIT=0, G_BIT=1, B_BIT=2
  - function onehot_rgb(idx)
- Sub-module rate_tick (parameter DIV), instantiated twice for blink and colour-step:
  - synchronous clear input
  - single-cycle tick every DIV cycles

## Test plan
Bench parameters: CLK_HZ=16, BLINK_HZ=2 (HALF=4), CYCLE_HZ=4 (STEP=4), COORD_W=3, COLOR_W=3.
1. Reset, then pos_sel=1 with x/y/z=5/2/7 → next cycle cur=5/2/7, cur_color=3'b111; disp_en pattern is 1 for 4 cycles, then 0 for 4 cycles, repeating.
2. Move to COL with c=3'b010 → cur_color=010, disp_en=1 steady, cur coordinates frozen when x changes to 1.
3. COL with c=0 → cur_color sequence 001,010,100,001, each held 4 cycles, starting 1 cycle after entry.
4. Commit edge in COL with wr_ready=0 for 3 cycles, then 1 → wr_valid high for 4 cycles with a stable payload, then returns to IDLE with disp_en=0.
5. pos_sel and col_sel both high → POS wins. Commit edge during POS → no write.
6. Reset asserted during COMMIT → wr_valid=0 next cycle, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/cursor_selector_pkg.sv
// Shared types and colour helpers for the LED-cube cursor/colour selector.
package cube_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POS    = 2'd1,
        COL    = 2'd2,
        COMMIT = 2'd3
    } sel_state_t;

    localparam int R_BIT = 0;
    localparam int G_BIT = 1;
    localparam int B_BIT = 2;

    // idx 0/1/2 -> R/G/B one-hot; anything else falls back to B
    function automatic logic [2:0] onehot_rgb(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd0:    v[R_BIT] = 1'b1;
            2'd1:    v[G_BIT] = 1'b1;
            default: v[B_BIT] = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cursor_selector_if.sv
// Frame-store write port of the cursor selector (valid/ready, payload held while valid).
interface cursor_selector_if #(
    parameter int COORD_W = 3,
    parameter int COLOR_W = 3
) ();
    logic               wr_valid;
    logic               wr_ready;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [COORD_W-1:0] wr_z;
    logic [COLOR_W-1:0] wr_color;

    modport master (output wr_valid, wr_x, wr_y, wr_z, wr_color, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_z, wr_color, output wr_ready);
endinterface

// File: rtl/cursor_selector_rate_tick.sv
// Free-running divider: one-cycle tick every DIV cycles, restartable by a synchronous clear.
module rate_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV) + 1;

    if (DIV < 1) begin : g_bad_div
        $error("rate_tick: DIV must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic          term;

    assign term = (cnt == CW'(DIV - 1));
    assign tick = term && !clr;

    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (term)    cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cursor_selector.sv
// Cursor/colour selection controller: previews a voxel cursor on the cube and
// commits the chosen voxel and colour to the frame store over a valid/ready port.
module cursor_selector
    import cube_pkg::*;
#(
    parameter int COORD_W  = 3,
    parameter int COLOR_W  = 3,
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 4,
    parameter int CYCLE_HZ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pos_sel,
    input  logic               col_sel,
    input  logic               commit,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] z,
    input  logic [COLOR_W-1:0] c,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [COORD_W-1:0] cur_z,
    output logic [COLOR_W-1:0] cur_color,
    output logic               disp_en,
    output logic               busy,
    cursor_selector_if.master  wr
);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int STEP = CLK_HZ / CYCLE_HZ;

    if (HALF < 1) begin : g_bad_half
        $error("cursor_selector: CLK_HZ/(2*BLINK_HZ) must be >= 1");
    end
    if (STEP < 1) begin : g_bad_step
        $error("cursor_selector: CLK_HZ/CYCLE_HZ must be >= 1");
    end
    if (COLOR_W < 3) begin : g_bad_color
        $error("cursor_selector: COLOR_W must be >= 3");
    end

    sel_state_t         state, nstate;
    logic               commit_q;
    logic [COLOR_W-1:0] c_q;
    logic [1:0]         cyc_idx, cyc_idx_d, cyc_idx_nxt;
    logic               rise;

    logic [COORD_W-1:0] cur_x_d, cur_y_d, cur_z_d;
    logic [COLOR_W-1:0] cur_color_d;
    logic               disp_en_d, busy_d, wr_valid_d;
    logic [COORD_W-1:0] wr_x_d, wr_y_d, wr_z_d;
    logic [COLOR_W-1:0] wr_color_d;

    logic blink_clr, blink_tick;
    logic cycling, restart, cyc_clr, cyc_tick;

    assign rise = commit && !commit_q;

    // Blink phase restarts on every entry to POS
    assign blink_clr = !((state == POS) && (nstate == POS));

    // Auto-cycle restarts at R on entry to COL and when c drops from non-zero to 0
    assign cycling     = (nstate == COL) && (c == '0);
    assign restart     = cycling && ((state != COL) || (c_q != '0));
    assign cyc_clr     = !cycling || restart;
    assign cyc_idx_nxt = (cyc_idx == 2'd2) ? 2'd0 : cyc_idx + 2'd1;

    rate_tick #(.DIV(HALF)) u_blink (
        .clk   (clk),
        .reset (reset),
        .clr   (blink_clr),
        .tick  (blink_tick)
    );

    rate_tick #(.DIV(STEP)) u_step (
        .clk   (clk),
        .reset (reset),
        .clr   (cyc_clr),
        .tick  (cyc_tick)
    );

    always_comb begin
        nstate      = state;
        cur_x_d     = cur_x;
        cur_y_d     = cur_y;
        cur_z_d     = cur_z;
        cur_color_d = cur_color;
        disp_en_d   = disp_en;
        cyc_idx_d   = cyc_idx;
        wr_x_d      = wr.wr_x;
        wr_y_d      = wr.wr_y;
        wr_z_d      = wr.wr_z;
        wr_color_d  = wr.wr_color;

        unique case (state)
            IDLE: begin
                if (pos_sel)      nstate = POS;
                else if (col_sel) nstate = COL;
            end
            POS: begin
                if (pos_sel)      nstate = POS;
                else if (col_sel) nstate = COL;
                else              nstate = IDLE;
            end
            COL: begin
                if (pos_sel)       nstate = POS;
                else if (!col_sel) nstate = IDLE;
                else if (rise)     nstate = COMMIT;
            end
            COMMIT: begin
                if (wr.wr_valid && wr.wr_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase

        unique case (nstate)
            IDLE: disp_en_d = 1'b0;
            POS: begin
                cur_x_d     = x;
                cur_y_d     = y;
                cur_z_d     = z;
                cur_color_d = COLOR_W'(3'b111);
                disp_en_d   = (state != POS) ? 1'b1 : (disp_en ^ blink_tick);
            end
            COL: begin
                disp_en_d = 1'b1;
                if (c != '0) begin
                    cur_color_d = c;
                end else if (restart) begin
                    cyc_idx_d   = 2'd0;
                    cur_color_d = COLOR_W'(onehot_rgb(2'd0));
                end else if (cyc_tick) begin
                    cyc_idx_d   = cyc_idx_nxt;
                    cur_color_d = COLOR_W'(onehot_rgb(cyc_idx_nxt));
                end
            end
            COMMIT: begin
                // Snapshot exactly what is on the display this cycle
                if (state != COMMIT) begin
                    wr_x_d     = cur_x;
                    wr_y_d     = cur_y;
                    wr_z_d     = cur_z;
                    wr_color_d = cur_color;
                end
            end
            default: disp_en_d = 1'b0;
        endcase

        wr_valid_d = (nstate == COMMIT);
        busy_d     = (nstate == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            commit_q    <= 1'b0;
            c_q         <= '0;
            cyc_idx     <= 2'd0;
            cur_x       <= '0;
            cur_y       <= '0;
            cur_z       <= '0;
            cur_color   <= '0;
            disp_en     <= 1'b0;
            busy        <= 1'b0;
            wr.wr_valid <= 1'b0;
            wr.wr_x     <= '0;
            wr.wr_y     <= '0;
            wr.wr_z     <= '0;
            wr.wr_color <= '0;
        end else begin
            state       <= nstate;
            commit_q    <= commit;
            c_q         <= c;
            cyc_idx     <= cyc_idx_d;
            cur_x       <= cur_x_d;
            cur_y       <= cur_y_d;
            cur_z       <= cur_z_d;
            cur_color   <= cur_color_d;
            disp_en     <= disp_en_d;
            busy        <= busy_d;
            wr.wr_valid <= wr_valid_d;
            wr.wr_x     <= wr_x_d;
            wr.wr_y     <= wr_y_d;
            wr.wr_z     <= wr_z_d;
            wr.wr_color <= wr_color_d;
        end
    end
endmodule

// File: tb/tb_cursor_selector.sv
// Scoreboard bench for cursor_selector: a cycle-level reference model fills expectation
// queues as stimulus is issued; independent monitors pop and compare DUT outputs.
module tb_cursor_selector;
    localparam int HALF = 4;   // 16 / (2*2)
    localparam int STEP = 4;   // 16 / 4

    logic       clk = 1'b0;
    logic       reset, pos_sel, col_sel, commit;
    logic [2:0] x, y, z, c;
    logic [2:0] cur_x, cur_y, cur_z, cur_color;
    logic       disp_en, busy;

    always #5 clk = ~clk;

    cursor_selector_if #(.COORD_W(3), .COLOR_W(3)) wr_if ();

    cursor_selector #(
        .COORD_W(3), .COLOR_W(3), .CLK_HZ(16), .BLINK_HZ(2), .CYCLE_HZ(4)
    ) dut (
        .clk(clk), .reset(reset), .pos_sel(pos_sel), .col_sel(col_sel), .commit(commit),
        .x(x), .y(y), .z(z), .c(c),
        .cur_x(cur_x), .cur_y(cur_y), .cur_z(cur_z), .cur_color(cur_color),
        .disp_en(disp_en), .busy(busy), .wr(wr_if)
    );

    typedef struct packed {
        logic [2:0] x, y, z, col;
        logic       disp, vld, busy;
        logic [2:0] wx, wy, wz, wc;
    } obs_t;

    typedef struct packed {
        logic [2:0] x, y, z, col;
    } wr_t;

    obs_t exp_q[$];
    logic dc_q[$];
    wr_t  wq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: mode 0 idle, 1 positioning, 2 colour, 3 writing
    int         m_mode = 0;
    int         pos_age = 0;
    int         col_age = 0;
    logic [2:0] m_prev_c = 3'd0;
    logic       m_prev_com = 1'b0;
    obs_t       m = '0;

    task automatic model_step();
        int   nm;
        logic rise;
        if (reset) begin
            m = '0; m_mode = 0; m_prev_c = 3'd0; m_prev_com = 1'b0;
            pos_age = 0; col_age = 0;
        end else begin
            rise = commit && !m_prev_com;
            nm = m_mode;
            case (m_mode)
                0: if (pos_sel) nm = 1; else if (col_sel) nm = 2;
                1: nm = pos_sel ? 1 : (col_sel ? 2 : 0);
                2: if (pos_sel) nm = 1; else if (!col_sel) nm = 0; else if (rise) nm = 3;
                default: if (wr_if.wr_ready) begin
                    wq.push_back({m.wx, m.wy, m.wz, m.wc});
                    nm = 0;
                end
            endcase
            case (nm)
                0: m.disp = 1'b0;
                1: begin
                    pos_age = (m_mode == 1) ? pos_age + 1 : 0;
                    m.x = x; m.y = y; m.z = z; m.col = 3'b111;
                    m.disp = ((pos_age / HALF) % 2) == 0;
                end
                2: begin
                    m.disp = 1'b1;
                    if (c != 3'd0) m.col = c;
                    else begin
                        col_age = (m_mode == 2 && m_prev_c == 3'd0) ? col_age + 1 : 0;
                        m.col = 3'(1 << ((col_age / STEP) % 3));
                    end
                end
                default: if (m_mode != 3) {m.wx, m.wy, m.wz, m.wc} = {m.x, m.y, m.z, m.col};
            endcase
            m.vld  = (nm == 3);
            m.busy = (nm == 3);
            m_mode = nm;
            m_prev_c = c;
            m_prev_com = commit;
        end
        exp_q.push_back(m);
        dc_q.push_back(m_mode == 3);  // display enable while writing is left open
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    // Per-cycle output monitor
    initial begin : mon_cycle
        obs_t e, a;
        logic dc;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                dc = dc_q.pop_front();
                a  = {cur_x, cur_y, cur_z, cur_color, disp_en, wr_if.wr_valid, busy,
                      wr_if.wr_x, wr_if.wr_y, wr_if.wr_z, wr_if.wr_color};
                if (dc) a.disp = e.disp;
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle%0d outputs: got %h expected %h", cyc, a, e);
                end
            end
        end
    end

    // Write-handshake monitor, sampled mid-cycle before the accepting edge
    initial begin : mon_write
        wr_t w, g;
        forever begin
            @(negedge clk); #2;
            if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1 && reset === 1'b0) begin
                g = {wr_if.wr_x, wr_if.wr_y, wr_if.wr_z, wr_if.wr_color};
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL write: unexpected write %h, none required", g);
                end else begin
                    w = wq.pop_front();
                    if (g !== w) begin
                        n_fail++;
                        $display("FAIL write: got %h required %h", g, w);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pos_sel = 1'b0; col_sel = 1'b0; commit = 1'b0;
        x = 3'd0; y = 3'd0; z = 3'd0; c = 3'd0; wr_if.wr_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Positioning with blink
        pos_sel = 1'b1; x = 3'd5; y = 3'd2; z = 3'd7;
        repeat (17) tick();

        // Fixed colour, coordinates frozen
        pos_sel = 1'b0; col_sel = 1'b1; c = 3'b010;
        repeat (3) tick();
        x = 3'd1;
        repeat (2) tick();

        // Auto-cycle
        c = 3'd0;
        repeat (14) tick();

        // Commit with back-pressure, then accept
        commit = 1'b1;
        tick();
        repeat (3) tick();
        wr_if.wr_ready = 1'b1; col_sel = 1'b0;
        tick();
        wr_if.wr_ready = 1'b0; commit = 1'b0;
        repeat (3) tick();

        // Both selects high: position wins; commit edge in POS is not a write
        pos_sel = 1'b1; col_sel = 1'b1; x = 3'd3; y = 3'd4; z = 3'd1; c = 3'b101;
        repeat (3) tick();
        commit = 1'b1;
        repeat (3) tick();
        // Commit held across COL entry does not write
        pos_sel = 1'b0;
        repeat (4) tick();

        // Reset during a pending write
        commit = 1'b0; tick();
        commit = 1'b1; tick();
        repeat (2) tick();
        reset = 1'b1; wr_if.wr_ready = 1'b1;
        tick();
        reset = 1'b0; wr_if.wr_ready = 1'b0; col_sel = 1'b0; commit = 1'b0;
        repeat (2) tick();

        // Randomized segments
        for (int k = 0; k < 60; k++) begin
            int len;
            len     = $urandom_range(1, 12);
            pos_sel = ($urandom_range(0, 9) < 2);
            col_sel = ($urandom_range(0, 9) < 7);
            c       = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom);
            for (int j = 0; j < len; j++) begin
                x = 3'($urandom); y = 3'($urandom); z = 3'($urandom);
                if ($urandom_range(0, 3) == 0) commit = ~commit;
                wr_if.wr_ready = 1'($urandom_range(0, 1));
                reset = ($urandom_range(0, 99) == 0);
                tick();
            end
        end

        reset = 1'b0; pos_sel = 1'b0; col_sel = 1'b0; commit = 1'b0; wr_if.wr_ready = 1'b1;
        repeat (3) tick();
        @(posedge clk); #3;

        n_tests++;
        if (wq.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: writes left %0d cycles left %0d, required 0 and 0",
                     wq.size(), exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
